// File: rtl/fpu_op_sequencer.sv
// fpu_op_sequencer: command FIFO feeding a single-issue bfloat16 FPU.
// Optional sticky flag accumulation is enabled by defining FPU_SEQ_FLAG_ACCUM_EN.
module fpu_op_sequencer #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst_l,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [4:0]  cmd_op,
    input  logic [15:0] cmd_rs1,
    input  logic [15:0] cmd_rs2,
    input  logic [15:0] cmd_rs3,
    input  logic [2:0]  cmd_rm,
    output logic        fpu_start,
    output logic [4:0]  fpu_op,
    output logic [15:0] fpu_a,
    output logic [15:0] fpu_b,
    output logic [15:0] fpu_c,
    output logic [2:0]  fpu_rm,
    input  logic        fpu_done,
    input  logic [15:0] fpu_result,
    input  logic [4:0]  fpu_flags,
    output logic        res_valid,
    output logic [15:0] res_data,
    output logic [4:0]  res_flags,
    input  logic        res_ready,
    output logic        busy,
    output logic        err_timeout,
    output logic [4:0]  acc_flags,
    input  logic        acc_clr
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [15:0] QNAN = 16'h7FC0;
    localparam logic [4:0]  NV   = 5'b10000;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} state_t;

    typedef struct packed {
        logic [4:0]  op;
        logic [15:0] rs1;
        logic [15:0] rs2;
        logic [15:0] rs3;
        logic [2:0]  rm;
    } cmd_t;

    cmd_t          mem_q [DEPTH];
    cmd_t          cmd_in;
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   cnt_q;
    logic          empty, full, push, pop;

    state_t        state_q, state_d;
    cmd_t          issue_q, issue_d;
    logic [15:0]   res_data_q, res_data_d;
    logic [4:0]    res_flags_q, res_flags_d;
    logic [CW-1:0] wcnt_q, wcnt_d;
    logic          err_q, err_d;

    assign cmd_in    = '{op: cmd_op, rs1: cmd_rs1, rs2: cmd_rs2,
                         rs3: cmd_rs3, rm: cmd_rm};
    assign empty     = (cnt_q == '0);
    assign full      = (cnt_q == (AW+1)'(DEPTH));
    assign cmd_ready = !full;
    assign push      = cmd_valid && cmd_ready;

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= cmd_in;
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    always_comb begin
        state_d     = state_q;
        issue_d     = issue_q;
        res_data_d  = res_data_q;
        res_flags_d = res_flags_q;
        wcnt_d      = '0;
        err_d       = err_q;
        pop         = 1'b0;
        fpu_start   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    issue_d = mem_q[rd_ptr_q];
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (issue_q.op[4]) begin
                    res_data_d  = QNAN;
                    res_flags_d = NV;
                    state_d     = HOLD;
                end else begin
                    fpu_start = 1'b1;
                    state_d   = WAIT;
                end
            end
            WAIT: begin
                if (fpu_done) begin
                    res_data_d  = fpu_result;
                    res_flags_d = fpu_flags;
                    state_d     = HOLD;
                end else if (wcnt_q == CW'(TIMEOUT - 1)) begin
                    // Give up on the FPU and return a canonical invalid result
                    res_data_d  = QNAN;
                    res_flags_d = NV;
                    err_d       = 1'b1;
                    state_d     = HOLD;
                end else begin
                    wcnt_d = wcnt_q + 1'b1;
                end
            end
            HOLD: begin
                if (res_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state_q     <= IDLE;
            issue_q     <= '0;
            res_data_q  <= '0;
            res_flags_q <= '0;
            wcnt_q      <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            issue_q     <= issue_d;
            res_data_q  <= res_data_d;
            res_flags_q <= res_flags_d;
            wcnt_q      <= wcnt_d;
            err_q       <= err_d;
        end
    end

    assign fpu_op      = issue_q.op;
    assign fpu_a       = issue_q.rs1;
    assign fpu_b       = issue_q.rs2;
    assign fpu_c       = issue_q.rs3;
    assign fpu_rm      = issue_q.rm;
    assign res_valid   = (state_q == HOLD);
    assign res_data    = res_data_q;
    assign res_flags   = res_flags_q;
    assign err_timeout = err_q;
    assign busy        = (state_q != IDLE) || !empty;

`ifdef FPU_SEQ_FLAG_ACCUM_EN
    logic [4:0] acc_q;

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            acc_q <= '0;
        end else if (acc_clr) begin
            acc_q <= '0;
        end else if (res_valid && res_ready) begin
            acc_q <= acc_q | res_flags_q;
        end
    end

    assign acc_flags = acc_q;
`else
    logic unused_acc_clr;
    assign unused_acc_clr = acc_clr;
    assign acc_flags      = 5'b0;
`endif

endmodule

// File: doc/fpu_op_sequencer.md
FPU_OP_SEQUENCER -- requirements
Module: fpu_op_sequencer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, command FIFO depth (power of two, 2..16).
REQ-002 SHALL have parameter TIMEOUT, default 64, max cycles spent in WAIT before abort.
REQ-003 SHALL have port clk, input, 1, single clock; all state on rising edge.
REQ-004 SHALL have port rst_l, input, 1, asynchronous active-low reset.
REQ-005 SHALL have ports cmd_valid (input, 1) and cmd_ready (output, 1), command push handshake.
REQ-006 SHALL have port cmd_op, input, 5, operation code; op[4]=1 is illegal.
REQ-007 SHALL have ports cmd_rs1, cmd_rs2, cmd_rs3, input, 16 each, bfloat16 operands.
REQ-008 SHALL have port cmd_rm, input, 3, rounding mode.
REQ-009 SHALL have port fpu_start, output, 1, one-cycle issue strobe to the FPU.
REQ-010 SHALL have ports fpu_op (output, 5), fpu_a/fpu_b/fpu_c (output, 16 each) and fpu_rm (output, 3), the issued operation.
REQ-011 SHALL have ports fpu_done (input, 1), fpu_result (input, 16) and fpu_flags (input, 5, NV/DZ/OF/UF/NX), FPU completion.
REQ-012 SHALL have ports res_valid (output, 1), res_data (output, 16), res_flags (output, 5) and res_ready (input, 1), result pop handshake.
REQ-013 SHALL have ports busy (output, 1), high when FSM is not IDLE or FIFO is non-empty; err_timeout (output, 1), sticky abort indicator.
REQ-014 SHALL have ports acc_flags (output, 5) and acc_clr (input, 1); see Configuration.

Function
REQ-015 SHALL buffer commands in a DEPTH-entry FIFO holding op, rs1, rs2, rs3 and rm.
REQ-016 SHALL drive cmd_ready = FIFO not full; a push occurs on cmd_valid & cmd_ready.
REQ-017 SHALL deassert cmd_ready when full even if a pop happens in the same cycle; a simultaneous push and pop on a non-full, non-empty FIFO SHALL leave occupancy unchanged.
REQ-018 SHALL implement FSM states IDLE, ISSUE, WAIT and HOLD.
REQ-019 IDLE: if FIFO is non-empty, SHALL pop the head into the issue registers and go to ISSUE.
REQ-020 ISSUE with legal op: SHALL assert fpu_start for exactly one cycle with fpu_* driven from the issue registers, then go to WAIT.
REQ-021 ISSUE with illegal op (op[4]=1): SHALL NOT assert fpu_start; SHALL load res_data=16'h7FC0 and res_flags=5'b10000, then go to HOLD.
REQ-022 fpu_op/fpu_a/fpu_b/fpu_c/fpu_rm SHALL remain stable from ISSUE until leaving WAIT.
REQ-023 WAIT: on fpu_done, SHALL capture fpu_result and fpu_flags into res_data and res_flags and go to HOLD.
REQ-024 Minimum latency from a push into an empty FIFO with FSM in IDLE to fpu_start SHALL be 2 cycles.
REQ-025 Latency from sampled fpu_done to res_valid SHALL be 1 cycle.
REQ-026 WAIT: when the cycle counter reaches TIMEOUT without fpu_done, SHALL load res_data=16'h7FC0 and res_flags=5'b10000, set err_timeout, and go to HOLD.
REQ-027 err_timeout SHALL stay set until reset.
REQ-028 HOLD: res_valid SHALL be 1 and res_data/res_flags stable; on res_ready, SHALL go to IDLE.
REQ-029 fpu_done SHALL be ignored in IDLE, ISSUE and HOLD.
REQ-030 Exactly one operation SHALL be outstanding at the FPU at any time; results SHALL be returned in command order.

Reset
REQ-031 On rst_l low, asynchronously: FSM=IDLE, FIFO emptied, fpu_start=0, res_valid=0, res_data=0, res_flags=0, fpu_op/a/b/c/rm=0, err_timeout=0, acc_flags=0, timeout counter=0.
REQ-032 Reset during WAIT SHALL discard the in-flight operation; a later fpu_done SHALL be ignored.
REQ-033 After rst_l rises, cmd_ready SHALL be 1 from the first clock edge.

Configuration
REQ-034 With FPU_SEQ_FLAG_ACCUM_EN defined, acc_flags SHALL OR in res_flags on each res_valid & res_ready, and acc_clr SHALL zero it; a clear in the same cycle as an accumulate SHALL win.
REQ-035 Without FPU_SEQ_FLAG_ACCUM_EN, acc_flags SHALL be constant 0 and acc_clr SHALL be ignored.

Verification
REQ-036 Push op=5'h02, rs1=16'h449A, rs2=16'h491E; FPU model returns 16'h5D44 after 3 cycles -> fpu_start 2 cycles after push; res_valid=1 with res_data=16'h5D44 1 cycle after fpu_done.
REQ-037 Push 5 commands back-to-back with res_ready=0 -> cmd_ready=0 after the 5th accepted push (DEPTH=4 plus 1 in flight); results drain in order once res_ready=1.
REQ-038 Push op=5'h10 -> no fpu_start; res_data=16'h7FC0, res_flags=5'b10000.
REQ-039 FPU model never asserts done -> after 64 WAIT cycles, res_data=16'h7FC0, err_timeout=1 until reset.
REQ-040 Assert rst_l low in WAIT, then pulse fpu_done -> res_valid stays 0, busy=0.
REQ-041 With FPU_SEQ_FLAG_ACCUM_EN, two results with flags 5'b00001 and 5'b00100 -> acc_flags=5'b00101; acc_clr -> 5'b00000.
